// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: opcodes, control bus widths and the opcode-to-control table
package decode_stage_pkg;
    localparam int NB_EX = 4;
    localparam int NB_MEM = 3;
    localparam int NB_WB = 2;
    localparam int MEM_READ_BIT = 2;
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LUI = 6'h0F, OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25, OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B;
    // ex = {reg_dst, alu_src, alu_op[1:0]}, mem = {mem_read, mem_write, branch}, wb = {reg_write, mem_to_reg}
    typedef struct packed {
        logic [NB_EX-1:0]  ex;
        logic [NB_MEM-1:0] mem;
        logic [NB_WB-1:0]  wb;
    } ctrl_t;
    localparam ctrl_t BUBBLE = '0;
    function automatic ctrl_t ctrl_of(input logic [5:0] op);
        case (op)
            OP_RTYPE:                                return '{4'b1010, 3'b000, 2'b10};
            OP_JAL:                                  return '{4'b0000, 3'b000, 2'b10};
            OP_BEQ, OP_BNE:                          return '{4'b0001, 3'b001, 2'b00};
            OP_ADDI:                                 return '{4'b0100, 3'b000, 2'b10};
            OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: return '{4'b0111, 3'b000, 2'b10};
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:     return '{4'b0100, 3'b100, 2'b11};
            OP_SB, OP_SH, OP_SW:                     return '{4'b0100, 3'b010, 2'b00};
            default:                                 return BUBBLE;
        endcase
    endfunction
endpackage

// File: rtl/decode_stage_if.sv
// decode_if: IF/ID side, writeback port and ID/EX side of the decode stage
interface decode_if #(parameter int LEN = 32, parameter int NB = 5);
    import decode_stage_pkg::*;
    logic              in_valid;
    logic [LEN-1:0]    in_pc_jump;
    logic [LEN-1:0]    in_instruccion;
    logic              in_flush;
    logic              RegWrite;
    logic [NB-1:0]     write_register;
    logic [LEN-1:0]    write_data;
    logic              out_stall;
    logic              out_valid;
    logic [LEN-1:0]    out_pc_jump;
    logic [LEN-1:0]    out_jump_addr;
    logic              out_jump;
    logic [LEN-1:0]    out_reg1;
    logic [LEN-1:0]    out_reg2;
    logic [LEN-1:0]    out_imm;
    logic [NB-1:0]     out_rs;
    logic [NB-1:0]     out_rt;
    logic [NB-1:0]     out_rd;
    logic [4:0]        out_shamt;
    logic [NB_EX-1:0]  execute_bus;
    logic [NB_MEM-1:0] memory_bus;
    logic [NB_WB-1:0]  writeBack_bus;
    modport master (
        output in_valid, in_pc_jump, in_instruccion, in_flush, RegWrite, write_register, write_data,
        input  out_stall, out_valid, out_pc_jump, out_jump_addr, out_jump, out_reg1, out_reg2, out_imm,
               out_rs, out_rt, out_rd, out_shamt, execute_bus, memory_bus, writeBack_bus
    );
    modport slave (
        input  in_valid, in_pc_jump, in_instruccion, in_flush, RegWrite, write_register, write_data,
        output out_stall, out_valid, out_pc_jump, out_jump_addr, out_jump, out_reg1, out_reg2, out_imm,
               out_rs, out_rt, out_rd, out_shamt, execute_bus, memory_bus, writeBack_bus
    );
endinterface

// File: rtl/decode_stage_regfile_bypass.sv
// regfile_bypass: NREGS x LEN register file, 2 read / 1 write, write-first bypass, sync clear
module regfile_bypass #(
    parameter int LEN = 32,
    parameter int NREGS = 32,
    parameter int NB = $clog2(NREGS)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           we,
    input  logic [NB-1:0]  wa,
    input  logic [LEN-1:0] wd,
    input  logic [NB-1:0]  ra1,
    input  logic [NB-1:0]  ra2,
    output logic [LEN-1:0] rd1,
    output logic [LEN-1:0] rd2
);
    logic [LEN-1:0] regs [NREGS];
    // clear everything on reset, otherwise write any register except r0
    always_ff @(posedge clk) begin
        if (!reset)
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        else if (we && wa != '0)
            regs[wa] <= wd;
    end
    assign rd1 = (ra1 == '0) ? '0 : (we && wa == ra1) ? wd : regs[ra1];
    assign rd2 = (ra2 == '0) ? '0 : (we && wa == ra2) ? wd : regs[ra2];
endmodule

// File: rtl/decode_stage.sv
// decode_stage: ID stage with regfile, immediate extension, jump target, load-use stall and ID/EX register
module decode_stage import decode_stage_pkg::*; #(
    parameter int LEN = 32,
    parameter int NREGS = 32,
    parameter int NB = $clog2(NREGS)
) (
    input logic clk,
    input logic reset,
    decode_if.slave d
);
    logic [5:0]     op;
    logic [NB-1:0]  rs, rt, rd;
    logic [LEN-1:0] rd1, rd2, imm;
    logic           bubble;
    ctrl_t          ctrl;
    assign op = d.in_instruccion[31:26];
    assign rs = NB'(d.in_instruccion[25:21]);
    assign rt = NB'(d.in_instruccion[20:16]);
    assign rd = NB'(d.in_instruccion[15:11]);
    assign ctrl = ctrl_of(op);
    assign imm = (op inside {OP_ANDI, OP_ORI, OP_XORI}) ? LEN'(d.in_instruccion[15:0]) :
                 (op == OP_LUI) ? LEN'({d.in_instruccion[15:0], 16'h0000}) :
                 {{(LEN-16){d.in_instruccion[15]}}, d.in_instruccion[15:0]};
    assign d.out_stall = d.out_valid && d.memory_bus[MEM_READ_BIT] && d.out_rt != '0 &&
                         (d.out_rt == rs || d.out_rt == rt) && d.in_valid && !d.in_flush;
    assign bubble = d.out_stall || d.in_flush || !d.in_valid;

    regfile_bypass #(.LEN(LEN), .NREGS(NREGS), .NB(NB)) u_rf (
        .clk(clk), .reset(reset), .we(d.RegWrite), .wa(d.write_register), .wd(d.write_data),
        .ra1(rs), .ra2(rt), .rd1(rd1), .rd2(rd2)
    );

    // ID/EX register: zeroed on reset or bubble, otherwise loads the decoded instruction
    always_ff @(posedge clk) begin
        if (!reset || bubble) begin
            d.out_valid     <= 1'b0;
            d.out_pc_jump   <= '0;
            d.out_jump_addr <= '0;
            d.out_jump      <= 1'b0;
            d.out_reg1      <= '0;
            d.out_reg2      <= '0;
            d.out_imm       <= '0;
            d.out_rs        <= '0;
            d.out_rt        <= '0;
            d.out_rd        <= '0;
            d.out_shamt     <= '0;
            d.execute_bus   <= BUBBLE.ex;
            d.memory_bus    <= BUBBLE.mem;
            d.writeBack_bus <= BUBBLE.wb;
        end else begin
            d.out_valid     <= 1'b1;
            d.out_pc_jump   <= d.in_pc_jump;
            d.out_jump_addr <= {d.in_pc_jump[LEN-1:28], d.in_instruccion[25:0], 2'b00};
            d.out_jump      <= op == OP_J || op == OP_JAL;
            d.out_reg1      <= rd1;
            d.out_reg2      <= rd2;
            d.out_imm       <= imm;
            d.out_rs        <= rs;
            d.out_rt        <= rt;
            d.out_rd        <= rd;
            d.out_shamt     <= d.in_instruccion[10:6];
            d.execute_bus   <= ctrl.ex;
            d.memory_bus    <= ctrl.mem;
            d.writeBack_bus <= ctrl.wb;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: randomized and directed checks of decode_stage against a behavioural model
module tb_decode_stage;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int passed = 0;
    int total = 0;

    decode_if #(.LEN(32), .NB(5)) bus();
    decode_stage dut (.clk(clk), .reset(reset), .d(bus));

    always #5 clk = ~clk;

    logic [31:0] mregs [32];
    logic        e_valid, e_jump, e_load, m_stall, obs_stall;
    logic [31:0] e_pc, e_ja, e_r1, e_r2, e_imm;
    logic [4:0]  e_rs, e_rt, e_rd, e_sh;
    logic [8:0]  e_ctrl;
    logic [5:0]  ops [20] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E,
                              6'h0F, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h23};
    wire [190:0] obs = {bus.out_valid, bus.out_pc_jump, bus.out_jump_addr, bus.out_jump, bus.out_reg1,
                        bus.out_reg2, bus.out_imm, bus.out_rs, bus.out_rt, bus.out_rd, bus.out_shamt,
                        bus.execute_bus, bus.memory_bus, bus.writeBack_bus};
    wire [190:0] expv = {e_valid, e_pc, e_ja, e_jump, e_r1, e_r2, e_imm, e_rs, e_rt, e_rd, e_sh, e_ctrl};

    function automatic logic [8:0] ctrl_exp(input logic [5:0] op);
        case (op)
            6'h00: return 9'b1010_000_10;
            6'h03: return 9'b0000_000_10;
            6'h04, 6'h05: return 9'b0001_001_00;
            6'h08: return 9'b0100_000_10;
            6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F: return 9'b0111_000_10;
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: return 9'b0100_100_11;
            6'h28, 6'h29, 6'h2B: return 9'b0100_010_00;
            default: return 9'b0;
        endcase
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd);
        return {6'h00, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0] op;
        op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 19)];
        return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 11'($urandom)};
    endfunction

    task automatic drive(input logic rn, input logic v, input logic [31:0] pc, input logic [31:0] instr,
                         input logic fl, input logic we, input logic [4:0] wa, input logic [31:0] wd);
        logic [5:0]  op;
        logic [4:0]  rs, rt;
        logic [31:0] r1, r2, im;
        logic        bub;
        @(negedge clk);
        reset = rn;
        bus.in_valid = v;
        bus.in_pc_jump = pc;
        bus.in_instruccion = instr;
        bus.in_flush = fl;
        bus.RegWrite = we;
        bus.write_register = wa;
        bus.write_data = wd;
        op = instr[31:26];
        rs = instr[25:21];
        rt = instr[20:16];
        m_stall = e_valid && e_load && e_rt != 0 && (e_rt == rs || e_rt == rt) && v && !fl;
        #1 obs_stall = bus.out_stall;
        bub = m_stall || fl || !v || !rn;
        r1 = (rs == 0) ? 32'd0 : (we && wa == rs) ? wd : mregs[rs];
        r2 = (rt == 0) ? 32'd0 : (we && wa == rt) ? wd : mregs[rt];
        if (op == 6'h0C || op == 6'h0D || op == 6'h0E) im = {16'h0, instr[15:0]};
        else if (op == 6'h0F) im = {instr[15:0], 16'h0};
        else im = {{16{instr[15]}}, instr[15:0]};
        @(posedge clk);
        e_valid = !bub;
        e_pc    = bub ? 32'd0 : pc;
        e_ja    = bub ? 32'd0 : {pc[31:28], instr[25:0], 2'b00};
        e_jump  = !bub && (op == 6'h02 || op == 6'h03);
        e_r1    = bub ? 32'd0 : r1;
        e_r2    = bub ? 32'd0 : r2;
        e_imm   = bub ? 32'd0 : im;
        e_rs    = bub ? 5'd0 : rs;
        e_rt    = bub ? 5'd0 : rt;
        e_rd    = bub ? 5'd0 : instr[15:11];
        e_sh    = bub ? 5'd0 : instr[10:6];
        e_ctrl  = bub ? 9'd0 : ctrl_exp(op);
        e_load  = !bub && (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25});
        if (!rn) for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        else if (we && wa != 0) mregs[wa] = wd;
        #1;
    endtask

    task automatic test_reset();
        drive(0, 1, $urandom, $urandom, 0, 1, 5'd3, $urandom);
        drive(1, 0, 0, 0, 0, 1, 5'd7, 32'h12345678);
        drive(0, 1, $urandom, rtype(7, 7, 1), 0, 1, 5'd9, $urandom);
        drive(0, 1, $urandom, rtype(7, 7, 1), 0, 0, 5'd0, 0);
        total++;
        if (obs !== '0) $display("FAIL reset_outputs got %h want 0", obs); else passed++;
        total++;
        if (obs_stall !== 1'b0) $display("FAIL reset_stall got %b want 0", obs_stall); else passed++;
        drive(1, 1, 32'h100, rtype(7, 9, 1), 0, 0, 5'd0, 0);
        total++;
        if ({bus.out_valid, bus.out_reg1, bus.out_reg2} !== {1'b1, 64'd0})
            $display("FAIL reset_regs_cleared got %b %h %h want 1 0 0", bus.out_valid, bus.out_reg1, bus.out_reg2);
        else passed++;
    endtask

    task automatic test_bypass();
        drive(1, 1, 32'h104, rtype(5, 0, 3), 0, 1, 5'd5, 32'hDEADBEEF);
        total++;
        if (bus.out_reg1 !== 32'hDEADBEEF) $display("FAIL bypass_same_cycle got %h want deadbeef", bus.out_reg1); else passed++;
        total++;
        if (obs !== expv) $display("FAIL bypass_vector got %h want %h", obs, expv); else passed++;
        drive(1, 1, 32'h108, rtype(0, 5, 3), 0, 0, 5'd0, 0);
        total++;
        if (bus.out_reg2 !== 32'hDEADBEEF) $display("FAIL bypass_stored got %h want deadbeef", bus.out_reg2); else passed++;
    endtask

    task automatic test_load_use();
        drive(1, 1, 32'h200, itype(6'h23, 1, 8, 16'h4), 0, 0, 5'd0, 0);
        total++;
        if (bus.out_valid !== 1'b1) $display("FAIL lu_load_issue got %b want 1", bus.out_valid); else passed++;
        drive(1, 1, 32'h204, rtype(8, 2, 9), 0, 0, 5'd0, 0);
        total++;
        if (obs_stall !== 1'b1) $display("FAIL lu_stall got %b want 1", obs_stall); else passed++;
        total++;
        if (bus.out_valid !== 1'b0) $display("FAIL lu_bubble got %b want 0", bus.out_valid); else passed++;
        drive(1, 1, 32'h204, rtype(8, 2, 9), 0, 0, 5'd0, 0);
        total++;
        if (obs_stall !== 1'b0) $display("FAIL lu_stall_clear got %b want 0", obs_stall); else passed++;
        total++;
        if ({bus.out_valid, bus.out_rs, bus.out_rd} !== {1'b1, 5'd8, 5'd9})
            $display("FAIL lu_issue got %b %0d %0d want 1 8 9", bus.out_valid, bus.out_rs, bus.out_rd);
        else passed++;
    endtask

    task automatic test_stall_flush();
        drive(1, 1, 32'h300, itype(6'h23, 1, 8, 16'h0), 0, 0, 5'd0, 0);
        drive(1, 1, 32'h304, rtype(8, 2, 9), 1, 0, 5'd0, 0);
        total++;
        if (obs_stall !== 1'b0) $display("FAIL flush_stall got %b want 0", obs_stall); else passed++;
        total++;
        if (bus.out_valid !== 1'b0) $display("FAIL flush_bubble got %b want 0", bus.out_valid); else passed++;
        drive(1, 1, 32'h404, itype(6'h0D, 3, 4, 16'h1), 0, 0, 5'd0, 0);
        total++;
        if ({bus.out_valid, bus.out_rt, bus.out_rd} !== {1'b1, 5'd4, 5'd0})
            $display("FAIL flush_next got %b %0d %0d want 1 4 0", bus.out_valid, bus.out_rt, bus.out_rd);
        else passed++;
    endtask

    task automatic test_imm();
        drive(1, 1, 32'h500, itype(6'h0D, 1, 2, 16'h8001), 0, 0, 5'd0, 0);
        total++;
        if (bus.out_imm !== 32'h00008001) $display("FAIL imm_ori got %h want 00008001", bus.out_imm); else passed++;
        drive(1, 1, 32'h504, itype(6'h08, 1, 2, 16'h8001), 0, 0, 5'd0, 0);
        total++;
        if (bus.out_imm !== 32'hFFFF8001) $display("FAIL imm_addi got %h want ffff8001", bus.out_imm); else passed++;
        drive(1, 1, 32'h508, itype(6'h0F, 0, 2, 16'h1234), 0, 0, 5'd0, 0);
        total++;
        if (bus.out_imm !== 32'h12340000) $display("FAIL imm_lui got %h want 12340000", bus.out_imm); else passed++;
    endtask

    task automatic test_jump();
        drive(1, 1, 32'h40000004, {6'h02, 26'h0000040}, 0, 0, 5'd0, 0);
        total++;
        if ({bus.out_jump, bus.out_jump_addr} !== {1'b1, 32'h40000100})
            $display("FAIL jump_target got %b %h want 1 40000100", bus.out_jump, bus.out_jump_addr);
        else passed++;
        drive(1, 1, 32'h40000008, rtype(0, 0, 1), 0, 1, 5'd0, 32'hFFFFFFFF);
        total++;
        if ({bus.out_jump, bus.out_reg1} !== {1'b0, 32'd0})
            $display("FAIL r0_bypass got %b %h want 0 0", bus.out_jump, bus.out_reg1);
        else passed++;
        drive(1, 1, 32'h4000000C, rtype(0, 0, 1), 0, 0, 5'd0, 0);
        total++;
        if (bus.out_reg1 !== 32'd0) $display("FAIL r0_stored got %h want 0", bus.out_reg1); else passed++;
    endtask

    task automatic test_random();
        logic [31:0] instr;
        instr = rand_instr();
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 63) != 0, $urandom_range(0, 99) < 85, $urandom, instr,
                  $urandom_range(0, 99) < 12, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
            total++;
            if (obs_stall !== m_stall) $display("FAIL rand_stall n=%0d got %b want %b", n, obs_stall, m_stall); else passed++;
            total++;
            if (obs !== expv) $display("FAIL rand_vector n=%0d got %h want %h", n, obs, expv); else passed++;
            if (!m_stall) instr = rand_instr();
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_load_use();
        test_stall_flush();
        test_imm();
        test_jump();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
